// File: rtl/pwm_audio_out.sv
// PWM audio output stage: 12-bit ramp driven from the mixer or a CPU sample FIFO.
// Registers and FIFO are reached over the MMIO valid/ready bus.
module pwm_audio_out #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [11:0] mix_in,
    output logic        pwm_out,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [2:0]    ctrl_q, ctrl_d;
    logic [15:0]   div_q, div_d;
    logic [11:0]   duty_q, duty_d;
    logic [11:0]   pwm_cnt_q, pwm_cnt_d;
    logic [15:0]   div_cnt_q, div_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   und_q, und_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          pwm_q, pwm_d;
    logic          irq_q, irq_d;
    logic [11:0]   mem_q [FIFO_DEPTH];

    logic        accept;
    logic        wr_en;
    logic [2:0]  sel;
    logic        en;
    logic        src;
    logic        full;
    logic        empty;
    logic        pwm_wrap;
    logic        reload;
    logic        pop;
    logic        underrun;
    logic        push_req;
    logic        push;
    logic        stat_wr;
    logic [6:0]  lvl7;
    logic [31:0] stat;
    logic [31:0] rd_val;
    logic        unused_ok;

    assign unused_ok = ^{addr[31:5], addr[1:0], wstrb[3:1], wdata[31:16]};

    assign accept   = valid & ~ready_q;
    assign wr_en    = accept & wstrb[0];
    assign sel      = addr[4:2];
    assign en       = ctrl_q[0];
    assign src      = ctrl_q[1];
    assign full     = (level_q == LW'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign pwm_wrap = en & (pwm_cnt_q == 12'hFFF);
    assign reload   = pwm_wrap & (div_cnt_q == div_q);
    assign pop      = reload & src & ~empty;
    assign underrun = reload & src & empty;
    assign push_req = wr_en & (sel == 3'd2);
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign push     = push_req & (~full | pop);
    assign stat_wr  = wr_en & (sel == 3'd3);
    assign lvl7     = 7'(level_q);
    assign stat     = {und_q, 5'd0, ovf_q, empty, full, 1'b0, lvl7};

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel == 3'd0: rd_val = {29'd0, ctrl_q};
            sel == 3'd1: rd_val = {16'd0, div_q};
            sel == 3'd3: rd_val = stat;
            default:     rd_val = '0;
        endcase
    end

    always_comb begin
        ready_d = accept;
        rdata_d = accept ? rd_val : rdata_q;
        ctrl_d  = ctrl_q;
        div_d   = div_q;
        if (wr_en && sel == 3'd0) begin
            ctrl_d = wdata[2:0];
        end
        if (wr_en && sel == 3'd1) begin
            div_d = wdata[15:0];
        end
    end

    always_comb begin
        pwm_cnt_d = '0;
        div_cnt_d = '0;
        pwm_d     = 1'b0;
        duty_d    = duty_q;
        if (en) begin
            pwm_cnt_d = pwm_cnt_q + 12'd1;
            pwm_d     = (pwm_cnt_q < duty_q);
            div_cnt_d = div_cnt_q;
            if (pwm_wrap) begin
                div_cnt_d = reload ? 16'd0 : div_cnt_q + 16'd1;
            end
        end
        if (reload) begin
            if (!src) begin
                duty_d = mix_in;
            end else if (!empty) begin
                duty_d = mem_q[rd_ptr_q];
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        ovf_d = ovf_q;
        und_d = und_q;
        if (stat_wr) begin
            ovf_d = 1'b0;
            und_d = '0;
        end else begin
            if (push_req && !push) begin
                ovf_d = 1'b1;
            end
            if (underrun && und_q != 16'hFFFF) begin
                und_d = und_q + 16'd1;
            end
        end
        // Derived from next-state so irq tracks the visible level exactly.
        irq_d = ctrl_d[2] & ctrl_d[1] & (level_d < LW'(FIFO_DEPTH / 2));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl_q    <= '0;
            div_q     <= DIV_RESET;
            duty_q    <= '0;
            pwm_cnt_q <= '0;
            div_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            und_q     <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            pwm_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            div_q     <= div_d;
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
            div_cnt_q <= div_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            und_q     <= und_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            pwm_q     <= pwm_d;
            irq_q     <= irq_d;
        end
    end

    assign ready   = ready_q;
    assign rdata   = rdata_q;
    assign pwm_out = pwm_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: directed scenarios plus random bus/mixer traffic,
// checked every cycle against a queue-based behavioural model.
module tb_pwm_audio_out;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [3:0]  wstrb = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [11:0] mix_in = '0;
    logic        pwm_out;
    logic        irq;

    pwm_audio_out #(.FIFO_DEPTH(D), .DIV_RESET(16'd0)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .ready(ready),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .rdata(rdata),
        .mix_in(mix_in), .pwm_out(pwm_out), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    // Behavioural model state
    bit m_en, m_src, m_ie, m_ovf, m_ready, m_pwm, m_irq;
    int m_div, m_duty, m_cnt, m_dc, m_und, m_rdata;
    int q[$];

    function automatic int stat_val();
        int s;
        s = (m_und << 16) | (int'(m_ovf) << 10) | q.size();
        if (q.size() == 0) s |= 32'h200;
        if (q.size() == D) s |= 32'h100;
        return s;
    endfunction

    task automatic model_step(input bit rn, input bit v, input bit ws,
                              input int a, input int wd, input int mx);
        bit acc, wr, popped;
        int pre, rv;
        if (!rn) begin
            m_en = 0; m_src = 0; m_ie = 0; m_ovf = 0;
            m_ready = 0; m_pwm = 0; m_irq = 0;
            m_div = 0; m_duty = 0; m_cnt = 0; m_dc = 0;
            m_und = 0; m_rdata = 0;
            q.delete();
            return;
        end
        acc = v && !m_ready;
        wr = acc && ws;
        if (acc) begin
            case (a)
                0: rv = int'({m_ie, m_src, m_en});
                1: rv = m_div;
                3: rv = stat_val();
                default: rv = 0;
            endcase
            m_rdata = rv;
        end
        m_ready = acc;
        pre = q.size();
        popped = 0;
        if (m_en) begin
            m_pwm = (m_cnt < m_duty);
            if (m_cnt == 4095) begin
                if (m_dc == m_div) begin
                    m_dc = 0;
                    if (!m_src) m_duty = mx;
                    else if (pre > 0) begin
                        m_duty = q.pop_front();
                        popped = 1;
                    end else if (m_und < 65535) m_und++;
                end else m_dc++;
            end
            m_cnt = (m_cnt + 1) % 4096;
        end else begin
            m_cnt = 0; m_dc = 0; m_pwm = 0;
        end
        if (wr) begin
            case (a)
                0: {m_ie, m_src, m_en} = wd[2:0];
                1: m_div = wd & 32'hFFFF;
                2: if (pre < D || popped) q.push_back(wd & 32'hFFF);
                   else m_ovf = 1;
                3: begin m_ovf = 0; m_und = 0; end
                default: ;
            endcase
        end
        m_irq = m_ie && m_src && (q.size() < D / 2);
    endtask

    task automatic tick();
        bit v, ws, rn;
        int a, wd, mx;
        v = valid; ws = wstrb[0]; a = int'(addr[4:2]);
        wd = wdata; mx = int'(mix_in); rn = resetn;
        @(posedge clk);
        model_step(rn, v, ws, a, wd, mx);
        #1;
        chk("pwm", pwm_out, m_pwm);
        chk("irq", irq, m_irq);
        chk("ready", ready, m_ready);
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic bus(input int a, input bit w, input int d);
        addr = a << 2;
        wstrb = w ? 4'hF : 4'h0;
        wdata = d;
        valid = 1'b1;
        tick();
        if (!m_ready) tick();
        chk("bus_ack", ready, 1);
        valid = 1'b0;
        wstrb = '0;
    endtask

    task automatic rd_chk(input string tag, input int a, input int exp);
        bus(a, 0, 0);
        chk(tag, rdata, exp);
    endtask

    int win_exp2[4] = '{0, 1024, 1024, 0};
    int win_exp3[10] = '{0, 0, 100, 100, 200, 200, 300, 300, 300, 300};

    initial begin
        int cnt;
        resetn = 1'b0;
        repeat (3) tick();
        chk("rst_ready", ready, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_irq", irq, 0);
        resetn = 1'b1;
        tick();
        for (int r = 0; r < 8; r++)
            rd_chk($sformatf("rst_reg%0d", r), r, (r == 3) ? 32'h200 : 0);

        // Mixer source, DIV=0, duty 1024 then 0
        bus(1, 1, 0);
        mix_in = 12'd1024;
        bus(0, 1, 1);
        for (int w = 0; w < 4; w++) begin
            cnt = 0;
            repeat (4096) begin tick(); cnt += int'(pwm_out); end
            chk($sformatf("mix_win%0d", w), cnt, win_exp2[w]);
            if (w == 1) mix_in = 12'd0;
        end

        // FIFO source, DIV=1, three samples then underrun
        bus(0, 1, 0);
        bus(1, 1, 1);
        bus(2, 1, 100);
        bus(2, 1, 200);
        bus(2, 1, 300);
        bus(0, 1, 3);
        for (int w = 0; w < 10; w++) begin
            cnt = 0;
            repeat (4096) begin tick(); cnt += int'(pwm_out); end
            chk($sformatf("fifo_win%0d", w), cnt, win_exp3[w]);
        end
        rd_chk("stat_und", 3, 32'h0002_0200);

        // Overflow with 9 pushes into depth 8
        bus(0, 1, 0);
        for (int i = 0; i < 9; i++) bus(2, 1, i * 7 + 1);
        bus(3, 0, 0);
        chk("ovf_full", rdata[8], 1);
        chk("ovf_flag", rdata[10], 1);
        chk("ovf_level", rdata[6:0], 8);
        bus(3, 1, 0);
        rd_chk("ovf_clr", 3, 32'h108);

        // irq threshold at level < 4
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        bus(0, 1, 6);
        for (int i = 0; i < 3; i++) bus(2, 1, 50 + i);
        chk("irq_lvl3", irq, 1);
        bus(2, 1, 53);
        chk("irq_lvl4", irq, 0);

        // Reset mid-period with FIFO level 5 and nonzero duty
        bus(2, 1, 54);
        mix_in = 12'd2000;
        bus(0, 1, 5);
        repeat (4096 + 100) tick();
        chk("pre_rst_pwm", pwm_out, 1);
        resetn = 1'b0;
        tick();
        chk("midrst_pwm", pwm_out, 0);
        resetn = 1'b1;
        tick();
        rd_chk("midrst_stat", 3, 32'h200);
        rd_chk("midrst_ctrl", 0, 0);
        bus(0, 1, 1);
        cnt = 0;
        repeat (100) begin tick(); cnt += int'(pwm_out); end
        chk("midrst_duty0", cnt, 0);

        // Random traffic against the model
        repeat (6000) begin
            int a;
            mix_in = 12'($urandom);
            if ($urandom_range(0, 11) == 0) begin
                a = $urandom_range(0, 7);
                case (a)
                    0: bus(a, $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)));
                    1: bus(a, $urandom_range(0, 1) == 1, int'($urandom_range(0, 2)));
                    default: bus(a, $urandom_range(0, 1) == 1, int'($urandom));
                endcase
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
